// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the ALU control decoder and the execution unit:
// op codes on alu_sel and the execution FSM state encoding.
package alu_defs;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_MULT = 4'd3;
  localparam logic [3:0] ALU_DIV  = 4'd4;
  localparam logic [3:0] ALU_LUI  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_NOP  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MUL    = 2'd1,
    ST_DIV    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/alu_exec_unit_muldiv_iter.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide,
// one step per cycle while i_step is high. For divide, o_hi holds the
// remainder and o_lo the quotient; for multiply {o_hi, o_lo} is the product.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32,
  parameter int CW    = $clog2(ITER)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_is_div,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [2*WIDTH-1:0] r_acc;    // product, or {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] r_mcand;  // multiplicand, shifted left each step
  logic [WIDTH-1:0]   r_opb;    // multiplier (shifted right) or divisor (held)
  logic               r_is_div;
  logic [CW-1:0]      r_cnt;

  logic [2*WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_acc;

  // One multiply step and one restoring-divide step, computed side by side.
  always_comb begin
    w_mul_acc = r_acc;
    if (r_opb[0]) begin
      w_mul_acc = r_acc + r_mcand;
    end else begin
      w_mul_acc = r_acc;
    end
    // Bring the next dividend bit into the partial remainder and trial-subtract.
    w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_opb};
    if (w_diff[WIDTH]) begin
      w_div_acc = {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end else begin
      w_div_acc = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end
  end

  // Operand load and per-cycle iteration with step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_opb    <= '0;
      r_is_div <= 1'b0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_acc    <= i_is_div ? {{WIDTH{1'b0}}, i_a} : '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_opb    <= i_b;
      r_is_div <= i_is_div;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_cnt <= r_cnt + CW'(1);
      if (r_is_div) begin
        r_acc <= w_div_acc;
      end else begin
        r_acc   <= w_mul_acc;
        r_mcand <= r_mcand << 1;
        r_opb   <= r_opb >> 1;
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_last = (r_cnt == CW'(ITER - 1));
  assign o_hi   = r_acc[2*WIDTH-1:WIDTH];
  assign o_lo   = r_acc[WIDTH-1:0];

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution stage: single-cycle logic/arithmetic ops, plus signed
// MULT/DIV run iteratively into HI/LO behind a start/busy/done handshake.
module alu_exec_unit
  import alu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  state_t r_state, w_next;

  logic [WIDTH-1:0] r_result, r_hi, r_lo, r_a_raw;
  logic             r_zero, r_busy, r_done, r_div_by_zero;
  logic             r_is_div, r_sign_q, r_sign_r, r_dbz;

  logic               w_accept, w_is_mul, w_is_div, w_b_zero, w_md_load, w_md_step, w_md_last;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_single, w_md_hi, w_md_lo, w_fin_hi, w_fin_lo;
  logic [2*WIDTH-1:0] w_prod;

  // start is only honoured while idle, i.e. when busy is low.
  assign w_accept  = start & (r_state == ST_IDLE);
  assign w_is_mul  = (alu_sel == ALU_MULT);
  assign w_is_div  = (alu_sel == ALU_DIV);
  assign w_b_zero  = (b == '0);
  assign w_abs_a   = a[WIDTH-1] ? -a : a;
  assign w_abs_b   = b[WIDTH-1] ? -b : b;
  assign w_md_load = w_accept & (w_is_mul | (w_is_div & ~w_b_zero));
  assign w_md_step = (r_state == ST_MUL) | (r_state == ST_DIV);

  muldiv_iter #(.WIDTH(WIDTH), .ITER(ITER)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_md_load),
    .i_is_div (w_is_div),
    .i_step   (w_md_step),
    .i_a      (w_abs_a),
    .i_b      (w_abs_b),
    .o_last   (w_md_last),
    .o_hi     (w_md_hi),
    .o_lo     (w_md_lo)
  );

  // Single-cycle op results; unmapped codes (and MULT/DIV here) give 0.
  always_comb begin
    w_single = '0;
    case (alu_sel)
      ALU_AND: w_single = a & b;
      ALU_OR:  w_single = a | b;
      ALU_ADD: w_single = a + b;
      ALU_SUB: w_single = a - b;
      ALU_LUI: w_single = b << 16;
      ALU_SLT: w_single = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: w_single = '0;
    endcase
  end

  // Apply operand signs to the unsigned iteration result, or the b==0 fallback.
  always_comb begin
    w_prod   = {w_md_hi, w_md_lo};
    w_fin_hi = w_md_hi;
    w_fin_lo = w_md_lo;
    if (r_dbz) begin
      w_fin_hi = r_a_raw;
      w_fin_lo = '1;
    end else if (r_is_div) begin
      // Quotient truncates toward zero; remainder takes the dividend's sign.
      w_fin_lo = r_sign_q ? -w_md_lo : w_md_lo;
      w_fin_hi = r_sign_r ? -w_md_hi : w_md_hi;
    end else begin
      w_prod   = r_sign_q ? -{w_md_hi, w_md_lo} : {w_md_hi, w_md_lo};
      w_fin_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fin_lo = w_prod[WIDTH-1:0];
    end
  end

  // Next-state logic for the multi-cycle sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_mul) begin
          w_next = ST_MUL;
        end else if (w_accept && w_is_div) begin
          w_next = w_b_zero ? ST_FINISH : ST_DIV;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (w_md_last) begin
          w_next = ST_FINISH;
        end else begin
          w_next = r_state;
        end
      end
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operand capture, single-cycle results and MULT/DIV write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result      <= '0;
      r_zero        <= 1'b0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_a_raw       <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_is_div      <= 1'b0;
      r_sign_q      <= 1'b0;
      r_sign_r      <= 1'b0;
      r_dbz         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (w_next != ST_IDLE);
      if (w_accept) begin
        r_is_div      <= w_is_div;
        r_sign_q      <= a[WIDTH-1] ^ b[WIDTH-1];
        r_sign_r      <= a[WIDTH-1];
        r_a_raw       <= a;
        r_dbz         <= w_is_div & w_b_zero;
        r_div_by_zero <= 1'b0;
        if (!w_is_mul && !w_is_div) begin
          r_result <= w_single;
          r_zero   <= (w_single == '0);
          r_done   <= 1'b1;
        end else begin
          r_result <= r_result;
        end
      end else if (r_state == ST_FINISH) begin
        r_hi          <= w_fin_hi;
        r_lo          <= w_fin_lo;
        r_result      <= w_fin_lo;
        r_zero        <= (w_fin_lo == '0);
        r_div_by_zero <= r_dbz;
        r_done        <= 1'b1;
      end else begin
        r_result <= r_result;
      end
    end
  end

  assign result      = r_result;
  assign zero        = r_zero;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized ops
// compared against a signed-arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  alu_sel;
  logic [31:0] a, b;
  logic [31:0] result, hi, lo;
  logic        zero, busy, done, div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference architectural state.
  logic [31:0] m_result = 32'd0;
  logic [31:0] m_hi     = 32'd0;
  logic [31:0] m_lo     = 32'd0;
  logic        m_dbz    = 1'b0;

  alu_exec_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .alu_sel     (alu_sel),
    .a           (a),
    .b           (b),
    .result      (result),
    .zero        (zero),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outcome of one op, from signed arithmetic on 64-bit integers.
  task automatic model(input logic [3:0] sel, input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] res, output logic [31:0] ehi, output logic [31:0] elo,
                       output logic edbz, output int lat);
    longint sa, sb, p, q, r;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ehi = m_hi; elo = m_lo; edbz = 1'b0; lat = 1; res = 32'd0;
    case (sel)
      4'd0: res = av & bv;
      4'd1: res = av | bv;
      4'd2: res = av + bv;
      4'd5: res = bv * 32'd65536;
      4'd6: res = av - bv;
      4'd7: res = (sa < sb) ? 32'd1 : 32'd0;
      4'd3: begin
        p = sa * sb;
        ehi = p[63:32]; elo = p[31:0]; res = elo; lat = 34;
      end
      4'd4: begin
        if (bv == 32'd0) begin
          elo = 32'hFFFFFFFF; ehi = av; edbz = 1'b1; lat = 2;
        end else begin
          q = sa / sb; r = sa % sb;
          elo = q[31:0]; ehi = r[31:0]; lat = 34;
        end
        res = elo;
      end
      default: res = 32'd0;
    endcase
  endtask

  // Issue one op in the current cycle and follow it to done (or to a reset).
  task automatic run_op(input logic [3:0] sel, input logic [31:0] av, input logic [31:0] bv,
                        input int inj, input int rst_at);
    logic [31:0] e_res, e_hi, e_lo;
    logic        e_dbz, seen;
    int          e_lat, lat;
    model(sel, av, bv, e_res, e_hi, e_lo, e_dbz, e_lat);
    start = 1'b1; alu_sel = sel; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; alu_sel = 4'($urandom); a = $urandom; b = $urandom;
    lat = 1; seen = 1'b0;
    while (lat <= 40) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      check("busy_run", busy, 1);
      check("hold_hi", hi, m_hi);
      check("hold_lo", lo, m_lo);
      check("dbz_clear", div_by_zero, 0);
      if (rst_at != 0 && lat == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_result", result, 0);
        check("rst_dbz", div_by_zero, 0);
        m_result = 32'd0; m_hi = 32'd0; m_lo = 32'd0; m_dbz = 1'b0;
        return;
      end
      if (inj != 0 && lat == inj) begin
        start = 1'b1; alu_sel = 4'd2; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("latency", lat, e_lat);
      check("busy_done", busy, 0);
      check("result", result, e_res);
      check("zero", zero, (e_res == 32'd0));
      check("hi", hi, e_hi);
      check("lo", lo, e_lo);
      check("div_by_zero", div_by_zero, e_dbz);
    end
    m_result = e_res; m_hi = e_hi; m_lo = e_lo; m_dbz = e_dbz;
  endtask

  // Idle cycles after a completion: done must drop, everything else holds.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("idle_result", result, m_result);
      check("idle_hi", hi, m_hi);
      check("idle_dbz", div_by_zero, m_dbz);
    end
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0:       v = 32'd0;
      1:       v = 32'hFFFFFFFF;
      2:       v = 32'h80000000;
      3:       v = 32'h7FFFFFFF;
      4:       v = 32'($urandom_range(0, 20));
      5:       v = 32'd0 - 32'($urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; alu_sel = 4'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 0);
    check("reset_zero", zero, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_dbz", div_by_zero, 0);
    rst = 1'b0;
    idle(1);

    // Directed cases; consecutive run_op calls start in the done cycle.
    run_op(4'd2, 32'h7FFFFFFF, 32'd1, 0, 0);
    run_op(4'd6, 32'd5, 32'd5, 0, 0);
    run_op(4'd7, 32'hFFFFFFFF, 32'd1, 0, 0);
    run_op(4'd5, 32'd0, 32'h00001234, 0, 0);
    run_op(4'd9, 32'h12345678, 32'h9ABCDEF0, 0, 0);
    idle(1);
    run_op(4'd3, 32'hFFFFFFFD, 32'd7, 10, 0);
    run_op(4'd4, 32'hFFFFFFF9, 32'd2, 0, 0);
    idle(2);
    run_op(4'd4, 32'd9, 32'd0, 0, 0);
    idle(1);
    run_op(4'd2, 32'd1, 32'd2, 0, 0);
    run_op(4'd4, 32'hFFFFFFF9, 32'd2, 0, 15);
    idle(2);
    run_op(4'd2, 32'd100, 32'd23, 0, 0);
    run_op(4'd4, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    run_op(4'd3, 32'h80000000, 32'h80000000, 0, 0);

    // Randomized ops, biased toward MULT/DIV and edge operands.
    for (int k = 0; k < 80; k++) begin
      logic [3:0] s;
      s = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(3, 4)) : 4'($urandom_range(0, 15));
      run_op(s, rnd_val(), rnd_val(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0, 0);
      idle($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution stage directly downstream of the ALU control decoder: consumes its 4-bit alu_sel plus two 32-bit operands and produces the result.
- Single-cycle logic/arithmetic ops; MULT and DIV run iteratively over 32 cycles into HI/LO registers.
- Start/busy/done handshake lets the pipeline control stall during multi-cycle ops.

Parameters:
- WIDTH, 32, operand/result width; HI/LO are each WIDTH bits.
- ITER, 32, iteration count for MULT/DIV; must equal WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  op request; sampled only when busy=0.
- alu_sel  input  4  op code from ALU control: 0 AND, 1 OR, 2 ADD, 3 MULT, 4 DIV, 5 LUI, 6 SUB, 7 SLT, 8-15 unmapped.
- a  input  WIDTH  operand A (rs).
- b  input  WIDTH  operand B (rt/immediate).
- result  output  WIDTH  registered result; valid when done=1.
- zero  output  1  result==0, registered with result.
- hi  output  WIDTH  HI register (product upper / remainder).
- lo  output  WIDTH  LO register (product lower / quotient).
- busy  output  1  multi-cycle op in progress.
- done  output  1  one-cycle pulse: result/hi/lo valid.
- div_by_zero  output  1  set with done for DIV with b==0; cleared on next accepted start.

Behaviour:
- Reset: all outputs 0, hi=lo=0, FSM to IDLE; applies mid-operation and aborts with no done pulse.
- FSM states: IDLE, MUL, DIV, FINISH.
- IDLE, start=1, single-cycle op (sel 0,1,2,5,6,7,8-15): result registered next edge. start at cycle N gives done=1 at N+1. FSM stays IDLE, busy stays 0.
- Op semantics:
  - AND/OR: bitwise.
  - ADD/SUB: modulo 2^WIDTH, no overflow trap.
  - LUI: b<<16.
  - SLT: signed compare, result 1 or 0.
  - Unmapped sel: result 0, zero=1.
- MULT, signed:
  - Start cycle N: latch |a|, |b| and sign=a[31]^b[31]; go to MUL.
  - MUL: 32 shift-add iterations, cycles N+1..N+32; then FINISH at N+33.
  - FINISH: negate the 64-bit product if sign=1, write {hi,lo}.
  - done=1 at N+34 with result=lo.
- DIV, signed, restoring:
  - Same timing as MULT.
  - lo=quotient, truncated toward zero. hi=remainder, sign follows a.
  - result=lo.
- DIV with b==0: skip the iterations; FINISH at N+1 writes lo=0xFFFFFFFF, hi=a. done and div_by_zero at N+2.
- busy: 1 from the cycle after start is accepted through FINISH; 0 in the done cycle.
- start while busy=1 is ignored; operands and sel are not re-sampled.
- start during the done cycle is accepted (back-to-back ops).
- hi/lo change only on MULT/DIV completion; single-cycle ops leave them untouched.
- done is a pulse and never held; result holds its value until the next completion.
- Iteration counter: 5 bits, counts 0..31. FINISH is entered when it reaches 31.

Decomposition:
- Shared package alu_defs holds:
  - op constants ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_MULT=3, ALU_DIV=4, ALU_LUI=5, ALU_SUB=6, ALU_SLT=7, ALU_NOP=8;
  - the FSM state encoding.
- The ALU control decoder imports the same package.
- One sub-module, muldiv_iter: iterative unsigned shift-add / restoring-divide datapath with counter. Sign handling, FSM and the single-cycle ops stay in alu_exec_unit.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 -> done at N+1, result=0x80000000, zero=0, busy never 1. SUB a=5, b=5 -> result 0, zero=1.
- SLT a=0xFFFFFFFF (-1), b=1 -> result 1. LUI b=0x1234 -> 0x12340000. sel=9 -> result 0, zero=1.
- MULT a=-3, b=7 -> busy 1 for N+1..N+33, done at N+34, hi=0xFFFFFFFF, lo=0xFFFFFFEB, result=lo. Prior hi/lo preserved until then.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF at N+34. DIV a=9, b=0 -> done and div_by_zero at N+2, lo=0xFFFFFFFF, hi=9.
- start with ADD pulsed at N+10 during MULT -> ignored, MULT completes correctly. New start in the done cycle -> accepted, done one cycle later.
- rst asserted at N+15 of a DIV -> next cycle busy=0, hi=lo=result=0, no done pulse. A fresh ADD afterwards completes normally.
